fifo_rd_unpack32: RTL and testbench



---
 rtl/fifo_rd_unpack32_if.sv | 26 ++
 rtl/fifo_rd_unpack32.sv | 104 ++++++++++
 tb/tb_fifo_rd_unpack32.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_unpack32_if.sv
// Bus bundle for fifo_rd_unpack32: command/status, FIFO read port and byte stream.
// slave = drain engine side, master = controller/FIFO/consumer side.
interface fifo_rd_unpack32_if #(parameter int CNT_W = 9);
   logic             start;
   logic             abort;
   logic [CNT_W-1:0] cfg_words;
   logic             busy;
   logic             done;
   logic [31:0]      fifo_data;
   logic             fifo_empty;
   logic             fifo_re;
   logic [7:0]       out_data;
   logic             out_valid;
   logic             out_ready;
   logic             out_last;

   modport slave (
      input  start, abort, cfg_words, fifo_data, fifo_empty, out_ready,
      output busy, done, fifo_re, out_data, out_valid, out_last
   );

   modport master (
      output start, abort, cfg_words, fifo_data, fifo_empty, out_ready,
      input  busy, done, fifo_re, out_data, out_valid, out_last
   );
endinterface

// File: rtl/fifo_rd_unpack32.sv
// FIFO drain engine: pops 32-bit words and streams them out little-endian, one byte per handshake.
// FIFO_UNPACK_BYPASS_EN chains the next word on the final-byte handshake (4 cycles/word, no FETCH bubble).
module fifo_rd_unpack32 #(
   parameter int CNT_W = 9
) (
   input  logic              clk,
   input  logic              rst,
   fifo_rd_unpack32_if.slave bus
);
   typedef enum logic [1:0] {IDLE, FETCH, SEND} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] words_left_q, words_left_d;
   logic [31:0]      shreg_q, shreg_d;
   logic [1:0]       byte_idx_q, byte_idx_d;
   logic             done_q, done_d;
   logic             hs, word_end, last_word, chain, pop;

   // abort swallows a coincident handshake, so it never advances the byte/word counters
   assign hs        = (state_q == SEND) & bus.out_ready & ~bus.abort;
   assign word_end  = hs & (byte_idx_q == 2'd3);
   assign last_word = (words_left_q == CNT_W'(1));

`ifdef FIFO_UNPACK_BYPASS_EN
   assign chain = word_end & ~last_word & ~bus.fifo_empty;
`else
   assign chain = 1'b0;
`endif

   assign pop = ((state_q == FETCH) & ~bus.fifo_empty & ~bus.abort) | chain;

   always_comb begin
      state_d      = state_q;
      words_left_d = words_left_q;
      shreg_d      = shreg_q;
      byte_idx_d   = byte_idx_q;
      done_d       = 1'b0;
      if (bus.abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  if (bus.cfg_words != '0) begin
                     words_left_d = bus.cfg_words;
                     state_d      = FETCH;
                  end else begin
                     done_d = 1'b1;
                  end
               end
            end
            FETCH: begin
               if (!bus.fifo_empty) begin
                  shreg_d    = bus.fifo_data;
                  byte_idx_d = 2'd0;
                  state_d    = SEND;
               end
            end
            SEND: begin
               if (hs) begin
                  shreg_d    = {8'h00, shreg_q[31:8]};
                  byte_idx_d = byte_idx_q + 2'd1;
                  if (word_end) begin
                     words_left_d = words_left_q - CNT_W'(1);
                     if (last_word) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                     end else if (chain) begin
                        shreg_d    = bus.fifo_data;
                        byte_idx_d = 2'd0;
                     end else begin
                        state_d = FETCH;
                     end
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         words_left_q <= '0;
         shreg_q      <= '0;
         byte_idx_q   <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         words_left_q <= words_left_d;
         shreg_q      <= shreg_d;
         byte_idx_q   <= byte_idx_d;
         done_q       <= done_d;
      end
   end

   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = done_q;
   assign bus.fifo_re   = pop;
   assign bus.out_data  = shreg_q[7:0];
   assign bus.out_valid = (state_q == SEND);
   assign bus.out_last  = (state_q == SEND) & (byte_idx_q == 2'd3) & last_word;
endmodule

// File: tb/tb_fifo_rd_unpack32.sv
// Bench for fifo_rd_unpack32: queue-modelled FIFO, expected byte stream built from the pushed words.
// Honours FIFO_UNPACK_BYPASS_EN for the throughput expectation.
module tb_fifo_rd_unpack32;
   localparam int CNT_W = 9;
`ifdef FIFO_UNPACK_BYPASS_EN
   localparam int SPAN4 = 16;
`else
   localparam int SPAN4 = 19;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fifo_rd_unpack32_if #(.CNT_W(CNT_W)) bus();
   fifo_rd_unpack32 #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      int          n;        // words made available
      int          cfg;      // programmed burst length
      int          rmode;    // 0 always ready, 1 pattern 1,0,0, 2 random
      int          pre;      // words present before start
      int          gap0;     // cycle of first late push
      int          gap1;     // spacing of further late pushes
      int          abort_at; // cycle abort is high, -1 none
      int          ign_at;   // cycle of a start pulse while busy, -1 none
      int          span;     // first..last out_valid cycles, -1 unchecked
      logic [31:0] w0;
      logic [31:0] w1;
   } vec_t;

   int n_chk = 0, n_fail = 0;
   int cyc, pops, done_cnt, done_cyc, last_hs_cyc, first_v, last_v, first_re;
   int rmode, abort_at, ign_at;
   bit busy_seen, prev_stall;
   logic [7:0] prev_d;
   logic prev_l;
   logic [31:0] fq[$];
   int          push_c[$];
   logic [31:0] push_w[$];
   logic [7:0]  got_b[$];
   logic        got_l[$];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   function automatic logic rdy(input int c);
      if (rmode == 0) return 1'b1;
      if (rmode == 1) return (c % 3) == 0;
      return $urandom_range(0, 3) != 0;
   endfunction

   task automatic drive_fifo();
      bus.fifo_empty = (fq.size() == 0);
      bus.fifo_data  = (fq.size() != 0) ? fq[0] : 32'hDEADBEEF;
   endtask

   // one cycle: sample on negedge, then apply FIFO/stimulus effects just after posedge
   task automatic step();
      logic re, hs;
      @(negedge clk);
      re = bus.fifo_re;
      hs = bus.out_valid & bus.out_ready & ~bus.abort;
      if (re) begin
         check("re_while_empty", bus.fifo_empty, 0);
         pops++;
         if (first_re < 0) first_re = cyc;
      end
      if (prev_stall) begin
         check("hold_valid", bus.out_valid, 1);
         check("hold_data", bus.out_data, prev_d);
         check("hold_last", bus.out_last, prev_l);
      end
      prev_stall = bus.out_valid & ~bus.out_ready & ~bus.abort;
      prev_d = bus.out_data;
      prev_l = bus.out_last;
      if (bus.busy) busy_seen = 1'b1;
      if (bus.out_valid) begin
         if (first_v < 0) first_v = cyc;
         last_v = cyc;
      end
      if (hs) begin
         got_b.push_back(bus.out_data);
         got_l.push_back(bus.out_last);
         if (bus.out_last) last_hs_cyc = cyc;
      end
      if (bus.done) begin
         done_cnt++;
         done_cyc = cyc;
         check("busy_at_done", bus.busy, 0);
      end
      if (abort_at >= 0 && cyc == abort_at + 1) begin
         check("abort_valid", bus.out_valid, 0);
         check("abort_busy", bus.busy, 0);
      end
      @(posedge clk);
      #1;
      if (re) void'(fq.pop_front());
      while (push_c.size() > 0 && push_c[0] == cyc) begin
         fq.push_back(push_w.pop_front());
         void'(push_c.pop_front());
      end
      cyc++;
      drive_fifo();
      bus.start = (cyc == ign_at);
      if (cyc == ign_at) bus.cfg_words = CNT_W'(7);
      bus.abort     = (cyc == abort_at);
      bus.out_ready = rdy(cyc);
   endtask

   task automatic clear_run();
      cyc = 0; pops = 0; done_cnt = 0; done_cyc = -1; last_hs_cyc = -1;
      first_v = -1; last_v = -1; first_re = -1;
      busy_seen = 1'b0; prev_stall = 1'b0;
      fq.delete(); push_c.delete(); push_w.delete(); got_b.delete(); got_l.delete();
   endtask

   task automatic run(input vec_t v);
      logic [31:0] w[$];
      logic [31:0] t;
      logic [7:0]  eb[$];
      logic        el[$];
      int          exp_pops;
      clear_run();
      rmode = v.rmode; abort_at = v.abort_at; ign_at = v.ign_at;
      for (int k = 0; k < v.n; k++) w.push_back(k == 0 ? v.w0 : (k == 1 ? v.w1 : $urandom()));
      for (int k = 0; k < v.n; k++) begin
         if (k < v.pre) fq.push_back(w[k]);
         else begin
            push_c.push_back(v.gap0 + (k - v.pre) * v.gap1);
            push_w.push_back(w[k]);
         end
      end
      // reference: cfg words in FIFO order, LSB byte first, last flag on the very last byte
      for (int k = 0; k < v.cfg; k++) begin
         t = w[k];
         for (int b = 0; b < 4; b++) begin
            eb.push_back(t[7:0]);
            el.push_back(k == v.cfg - 1 && b == 3);
            t = t >> 8;
         end
      end
      if (v.abort_at >= 0) begin
         while (eb.size() > v.abort_at - 2) begin
            void'(eb.pop_back());
            void'(el.pop_back());
         end
      end
      exp_pops = (v.abort_at >= 0) ? 1 : v.cfg;

      @(posedge clk);
      #1;
      drive_fifo();
      bus.start = 1'b1;
      bus.cfg_words = CNT_W'(v.cfg);
      bus.abort = (abort_at == 0);
      bus.out_ready = rdy(0);
      while (cyc < 2000) begin
         step();
         if (done_cnt > 0 || (v.abort_at >= 0 && cyc > v.abort_at + 4)) break;
      end
      if (cyc >= 2000) check("timeout", 1, 0);
      repeat (4) step();

      check("n_bytes", got_b.size(), eb.size());
      for (int i = 0; i < eb.size() && i < got_b.size(); i++) begin
         check("byte", got_b[i], eb[i]);
         check("last", got_l[i], el[i]);
      end
      check("pops", pops, exp_pops);
      check("done_cnt", done_cnt, (v.abort_at >= 0) ? 0 : 1);
      check("fifo_left", fq.size() + push_c.size(), v.n - exp_pops);
      if (v.cfg == 0) begin
         check("done_lat_zero", done_cyc, 1);
         check("busy_zero", busy_seen, 0);
         check("no_valid_zero", first_v, -1);
      end else if (v.abort_at < 0) begin
         check("done_lat", done_cyc, last_hs_cyc + 1);
      end
      if (v.cfg > 0 && v.pre > 0) begin
         check("start_to_re", first_re, 1);
         check("re_to_valid", first_v, 2);
      end
      if (v.span > 0) check("span", last_v - first_v + 1, v.span);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[8];
      vec_t rv;
      int   pb;
      tbl[0] = '{1, 1, 0, 1, 0, 0, -1, -1, 4,     32'h44332211, 32'h0};
      tbl[1] = '{1, 1, 1, 1, 0, 0, -1, -1, -1,    32'h44332211, 32'h0};
      tbl[2] = '{2, 2, 0, 0, 10, 20, -1, -1, -1,  32'hAABBCCDD, 32'h01020304};
      tbl[3] = '{4, 4, 0, 4, 0, 0, -1, -1, SPAN4, 32'hCAFEF00D, 32'h12345678};
      tbl[4] = '{1, 0, 0, 1, 0, 0, -1, -1, -1,    32'h55AA55AA, 32'h0};
      tbl[5] = '{3, 2, 0, 3, 0, 0, -1, 6, -1,     32'h0BADC0DE, 32'h87654321};
      tbl[6] = '{3, 3, 0, 3, 0, 0, 4, -1, -1,     32'hA1B2C3D4, 32'hE5F60718};
      tbl[7] = '{6, 5, 2, 6, 0, 0, -1, -1, -1,    32'h13579BDF, 32'h2468ACE0};

      rst = 1'b1;
      bus.start = 1'b0; bus.abort = 1'b0; bus.cfg_words = '0;
      bus.fifo_data = 32'h0; bus.fifo_empty = 1'b1; bus.out_ready = 1'b0;
      rmode = 0; abort_at = -1; ign_at = -1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_valid", bus.out_valid, 0);
      check("rst_last", bus.out_last, 0);
      check("rst_data", bus.out_data, 0);
      check("rst_re", bus.fifo_re, 0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) run(tbl[i]);

      for (int i = 0; i < 12; i++) begin
         rv.n = $urandom_range(1, 5);
         rv.cfg = $urandom_range(1, rv.n);
         rv.rmode = 2;
         rv.pre = $urandom_range(0, rv.n);
         rv.gap0 = $urandom_range(1, 8);
         rv.gap1 = $urandom_range(1, 10);
         rv.abort_at = -1; rv.ign_at = -1; rv.span = -1;
         rv.w0 = $urandom(); rv.w1 = $urandom();
         run(rv);
      end

      // reset in the middle of a 3-word burst
      clear_run();
      rmode = 0; abort_at = -1; ign_at = -1;
      fq.push_back(32'h11111111); fq.push_back(32'h22222222); fq.push_back(32'h33333333);
      @(posedge clk);
      #1;
      drive_fifo();
      bus.start = 1'b1; bus.cfg_words = CNT_W'(3); bus.out_ready = 1'b1;
      repeat (7) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      pb = pops;
      @(negedge clk);
      check("mrst_busy", bus.busy, 0);
      check("mrst_valid", bus.out_valid, 0);
      check("mrst_last", bus.out_last, 0);
      check("mrst_data", bus.out_data, 0);
      check("mrst_re", bus.fifo_re, 0);
      busy_seen = 1'b0;
      repeat (5) step();
      check("mrst_no_pops", pops, pb);
      check("mrst_idle", busy_seen, 0);
      check("mrst_no_done", done_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
